dft_sample_feeder: RTL and testbench

- Upstream stage of the DFT core: captures one frame of N time-domain samples, then streams them to the DFT input with a valid/ready handshake.
- Marks frame boundaries with first/last flags so the DFT knows where each transform, and its SSE computation, starts and ends.
- Single-buffered: it loads, then streams, then returns to loading.

---
 rtl/dft_sample_feeder.sv | 153 +++++++++++++++
 tb/tb_dft_sample_feeder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_sample_feeder.sv
// dft_sample_feeder: captures one frame of N samples into a register array, then streams it
// to the DFT input over a valid/ready handshake with first/last frame markers.
// Single-buffered: LOAD -> READY -> STREAM -> LOAD.
// Optional macro DFT_FEEDER_BIT_REVERSE_EN: stream in bit-reversed address order (radix-2 DIT).
module dft_sample_feeder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N      = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              frame_go,
  output logic              busy,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DATA_W-1:0] s_data,
  output logic [ADDR_W-1:0] s_index,
  output logic              s_first,
  output logic              s_last,
  output logic [15:0]       frame_cnt,
  output logic              overflow_err
);

  localparam logic [ADDR_W-1:0] LastPos = ADDR_W'(N - 1);

  typedef enum logic [1:0] {StLoad, StReady, StStream} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [DATA_W-1:0] r_mem [N];
  logic              r_busy;
  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_data;
  logic [ADDR_W-1:0] r_s_index;
  logic              r_s_first;
  logic              r_s_last;
  logic [15:0]       r_frame_cnt;
  logic              r_overflow;

  logic [ADDR_W-1:0] w_next_pos;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_first_addr;
  logic              w_xfer;
  logic              w_load_wr;

  // Map a stream position to the buffer address it is read from.
  function automatic logic [ADDR_W-1:0] f_order(input logic [ADDR_W-1:0] p);
    logic [ADDR_W-1:0] a;
`ifdef DFT_FEEDER_BIT_REVERSE_EN
    for (int i = 0; i < int'(ADDR_W); i++) begin
      a[i] = p[int'(ADDR_W) - 1 - i];
    end
`else
    a = p;
`endif
    return a;
  endfunction

  // Next stream position/address and handshake qualifiers.
  always_comb begin
    w_next_pos   = r_rd_ptr + 1'b1;
    w_next_addr  = f_order(w_next_pos);
    w_first_addr = f_order('0);
    w_xfer       = r_s_valid && s_ready;
    w_load_wr    = (r_state == StLoad) && wr_en;
  end

  // Sample storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_load_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Frame FSM with registered stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StLoad;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_busy      <= 1'b0;
      r_s_valid   <= 1'b0;
      r_s_data    <= '0;
      r_s_index   <= '0;
      r_s_first   <= 1'b0;
      r_s_last    <= 1'b0;
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      // Writes outside LOAD are dropped and flagged until reset.
      if (wr_en && (r_state != StLoad)) begin
        r_overflow <= 1'b1;
      end
      unique case (r_state)
        StLoad: begin
          // frame_go is ignored here, including on the final write edge.
          if (wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_wr_ptr == LastPos) begin
              r_state <= StReady;
              r_busy  <= 1'b1;
            end
          end
        end
        StReady: begin
          if (frame_go) begin
            r_state   <= StStream;
            r_rd_ptr  <= '0;
            r_s_valid <= 1'b1;
            r_s_data  <= r_mem[w_first_addr];
            r_s_index <= w_first_addr;
            r_s_first <= 1'b1;
            r_s_last  <= 1'b0;
          end
        end
        StStream: begin
          if (w_xfer) begin
            if (r_rd_ptr == LastPos) begin
              r_state     <= StLoad;
              r_busy      <= 1'b0;
              r_rd_ptr    <= '0;
              r_s_valid   <= 1'b0;
              r_s_first   <= 1'b0;
              r_s_last    <= 1'b0;
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
              // Load the next sample on the same edge: no bubble between transfers.
              r_rd_ptr  <= w_next_pos;
              r_s_data  <= r_mem[w_next_addr];
              r_s_index <= w_next_addr;
              r_s_first <= 1'b0;
              r_s_last  <= (w_next_pos == LastPos);
            end
          end
        end
        default: r_state <= StLoad;
      endcase
    end
  end

  assign busy         = r_busy;
  assign s_valid      = r_s_valid;
  assign s_data       = r_s_data;
  assign s_index      = r_s_index;
  assign s_first      = r_s_first;
  assign s_last       = r_s_last;
  assign frame_cnt    = r_frame_cnt;
  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_dft_sample_feeder.sv
// Self-checking bench for dft_sample_feeder with randomized stimulus and a frame-level model.
module tb_dft_sample_feeder;

  localparam int DW = 16;
  localparam int NS = 64;
  localparam int AW = 6;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          frame_go;
  logic          busy;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [AW-1:0] s_index;
  logic          s_first;
  logic          s_last;
  logic [15:0]   frame_cnt;
  logic          overflow_err;

  int n_cmp;
  int n_err;

  // Model state: the frame as written, completed-frame count, sticky overflow.
  logic [DW-1:0] exp_mem [NS];
  int            exp_frames;
  bit            exp_ovf;

  dft_sample_feeder #(
    .DATA_W(DW),
    .N     (NS),
    .ADDR_W(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .frame_go    (frame_go),
    .busy        (busy),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_index     (s_index),
    .s_first     (s_first),
    .s_last      (s_last),
    .frame_cnt   (frame_cnt),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer address of stream position p.
  function automatic int ord(input int p);
    int r;
`ifdef DFT_FEEDER_BIT_REVERSE_EN
    r = 0;
    for (int b = 0; b < AW; b++) r = r * 2 + ((p / (1 << b)) % 2);
`else
    r = p;
`endif
    return r;
  endfunction

  // Writes a full frame; random gaps and frame_go noise when rand_mode is set.
  task automatic load_frame(input bit seq, input bit rand_mode);
    for (int i = 0; i < NS; i++) begin
      while (rand_mode && ($urandom_range(0, 2) == 0)) begin
        wr_en    = 1'b0;
        frame_go = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      exp_mem[i] = seq ? DW'(i) : DW'($urandom);
      wr_en      = 1'b1;
      wr_data    = exp_mem[i];
      frame_go   = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    wr_en    = 1'b0;
    frame_go = 1'b0;
  endtask

  task automatic pulse_go();
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
  endtask

  // Streams one frame against the model; returns early after abort_at transfers (if >= 0).
  task automatic do_stream(input bit rand_ready, input bit inject_wr, input int abort_at);
    int            pos;
    int            cyc;
    bit            stalled;
    bit            rdy;
    logic [DW-1:0] held_data;
    logic [AW-1:0] held_idx;
    pos = 0; cyc = 0; stalled = 1'b0;
    held_data = '0; held_idx = '0;
    while (pos < NS && cyc < 4000) begin
      cyc++;
      if (abort_at >= 0 && pos == abort_at) return;
      n_cmp++;
      if (s_valid !== 1'b1 || s_data !== exp_mem[ord(pos)] || s_index !== AW'(ord(pos)) ||
          s_first !== (pos == 0) || s_last !== (pos == NS - 1)) begin
        n_err++;
        $display("FAIL stream pos %0d: valid=%b data=%h idx=%0d first=%b last=%b, want 1 %h %0d %b %b",
                 pos, s_valid, s_data, s_index, s_first, s_last, exp_mem[ord(pos)], ord(pos),
                 pos == 0, pos == NS - 1);
      end
      if (stalled) begin
        n_cmp++;
        if (s_data !== held_data || s_index !== held_idx) begin
          n_err++;
          $display("FAIL stall hold pos %0d: data=%h idx=%0d, want %h %0d",
                   pos, s_data, s_index, held_data, held_idx);
        end
      end
      rdy      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      s_ready  = rdy;
      wr_en    = inject_wr ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_data  = 16'hBEEF;
      frame_go = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      if (inject_wr && wr_en) exp_ovf = 1'b1;
      held_data = s_data;
      held_idx  = s_index;
      stalled   = !rdy;
      if (rdy) pos++;
      @(negedge clk);
    end
    s_ready = 1'b0; wr_en = 1'b0; frame_go = 1'b0;
    n_cmp++;
    if (pos != NS) begin
      n_err++;
      $display("FAIL stream timeout: transfers=%0d, want %0d", pos, NS);
    end else begin
      exp_frames = (exp_frames + 1) % 65536;
    end
    n_cmp++;
    if (s_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL frame end: valid=%b busy=%b cnt=%0d, want 0 0 %0d",
               s_valid, busy, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; frame_go = 1'b0; s_ready = 1'b0;
    #3 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      wr_en = 1'($urandom_range(0, 1)); wr_data = DW'($urandom);
      frame_go = 1'($urandom_range(0, 1)); s_ready = 1'($urandom_range(0, 1));
    end
    n_cmp++;
    if ({busy, s_valid, s_data, s_index, s_first, s_last, frame_cnt, overflow_err} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: busy=%b valid=%b data=%h idx=%0d first=%b last=%b cnt=%0d ovf=%b, want all 0",
               busy, s_valid, s_data, s_index, s_first, s_last, frame_cnt, overflow_err);
    end
    wr_en = 1'b0; frame_go = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_frames = 0; exp_ovf = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL after reset release: busy=%b valid=%b, want 0 0", busy, s_valid);
    end
  endtask

  task automatic test_basic_frame();
    load_frame(1'b1, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic ready: busy=%b valid=%b, want 1 0", busy, s_valid);
    end
    pulse_go();
    do_stream(1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    load_frame(1'b1, 1'b1);
    pulse_go();
    do_stream(1'b1, 1'b0, -1);
  endtask

  task automatic test_overflow();
    n_cmp++;
    if (overflow_err !== 1'b0) begin
      n_err++;
      $display("FAIL overflow before: ovf=%b, want 0", overflow_err);
    end
    load_frame(1'b1, 1'b0);
    // A dropped write while waiting in READY also counts.
    wr_en = 1'b1; wr_data = 16'hBEEF; exp_ovf = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    pulse_go();
    do_stream(1'b1, 1'b1, -1);
    n_cmp++;
    if (overflow_err !== exp_ovf) begin
      n_err++;
      $display("FAIL overflow set: ovf=%b, want %b", overflow_err, exp_ovf);
    end
    load_frame(1'b0, 1'b1);
    pulse_go();
    do_stream(1'b0, 1'b0, -1);
    n_cmp++;
    if (overflow_err !== 1'b1) begin
      n_err++;
      $display("FAIL overflow sticky: ovf=%b, want 1", overflow_err);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < NS; i++) begin
      exp_mem[i] = DW'($urandom);
      wr_en = 1'b1; wr_data = exp_mem[i];
      frame_go = (i == NS - 1) || (i == 5);
      @(negedge clk);
    end
    wr_en = 1'b0; frame_go = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (s_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL go on last write: valid=%b busy=%b, want 0 1", s_valid, busy);
    end
    pulse_go();
    do_stream(1'b1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_stream();
    load_frame(1'b0, 1'b0);
    pulse_go();
    do_stream(1'b0, 1'b0, 10);
    s_ready = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (s_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0 || overflow_err !== 1'b0) begin
      n_err++;
      $display("FAIL async reset: valid=%b busy=%b cnt=%0d ovf=%b, want 0 0 0 0",
               s_valid, busy, frame_cnt, overflow_err);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_frames = 0; exp_ovf = 1'b0;
    @(negedge clk);
    load_frame(1'b0, 1'b1);
    pulse_go();
    do_stream(1'b1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      load_frame(1'b0, 1'b0);
      pulse_go();
      do_stream(1'b0, 1'b0, -1);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_frames = 0; exp_ovf = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_overflow();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
